internal_bus_arbiter: RTL and testbench

- Parametrised multi-channel master for the core's internal bus; the next generation of the fixed-wiring bus block, where sub-managers OR their outputs together.
- Arbitrates NCH requester channels (mem manager, thread controller, ALU spill, dispatcher, ...) onto one read_q/write_q + read_dn/write_dn handshake, round-robin.
- Tracks one outstanding transaction at a time.
- Returns read data and per-channel completion/error to each requester.

---
 rtl/internal_bus_arbiter_pkg.sv | 36 +++
 rtl/internal_bus_arbiter_if.sv | 42 ++++
 rtl/internal_bus_arbiter_rr_arbiter.sv | 46 ++++
 rtl/internal_bus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_internal_bus_arbiter.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/internal_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// internal_bus_arbiter_pkg
//   Shared definitions for the internal bus arbiter and its helpers:
//   FSM state encodings, bus operation encodings, default widths and a
//   small helper that sizes channel index vectors.
//
//   Contents:
//     IBA_DEF_*      default parameter values (NCH, ADDR_W, DATA_W, TMO_W)
//     iba_state_e    IBA_IDLE / IBA_ISSUE / IBA_DONE
//     iba_op_e       OP_RD / OP_WR
//     iba_idx_w()    width of a channel index for n channels (minimum 1)
// -----------------------------------------------------------------------------
package internal_bus_arbiter_pkg;

    localparam int IBA_DEF_NCH    = 4;
    localparam int IBA_DEF_ADDR_W = 32;
    localparam int IBA_DEF_DATA_W = 32;
    localparam int IBA_DEF_TMO_W  = 8;

    typedef enum logic [1:0] {
        IBA_IDLE  = 2'd0,
        IBA_ISSUE = 2'd1,
        IBA_DONE  = 2'd2
    } iba_state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } iba_op_e;

    // A 2-channel arbiter still needs a 1-bit index.
    function automatic int iba_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/internal_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// internal_bus_arbiter_if
//   Bus-side handshake of the internal bus arbiter. The arbiter is the master;
//   the bus/memory side is the slave.
//
//   Signals:
//     bus_busy  slave->master  external bus owner present, blocks new grants
//     addr_out  master->slave  bus address, all-zero when not issuing
//     data_out  master->slave  write data, all-zero unless a write is issuing
//     data_in   slave->master  read data
//     read_q    master->slave  read request strobe (level)
//     write_q   master->slave  write request strobe (level)
//     read_dn   slave->master  read complete
//     write_dn  slave->master  write complete
// -----------------------------------------------------------------------------
interface internal_bus_arbiter_if
    import internal_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = IBA_DEF_ADDR_W,
    parameter int DATA_W = IBA_DEF_DATA_W
);

    logic              bus_busy;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_in;
    logic              read_q;
    logic              write_q;
    logic              read_dn;
    logic              write_dn;

    modport master (
        input  bus_busy, data_in, read_dn, write_dn,
        output addr_out, data_out, read_q, write_q
    );

    modport slave (
        output bus_busy, data_in, read_dn, write_dn,
        input  addr_out, data_out, read_q, write_q
    );

endinterface

// File: rtl/internal_bus_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker. Scans the request vector starting at
//   ptr+1 and wrapping modulo N; the first set bit wins. The caller owns the
//   pointer register, so the same picker can be reused by other blocks.
//
//   Ports:
//     req      in   N    request vector
//     ptr      in   IW   index of the most recently served requester
//     valid    out  1    at least one request present
//     gnt_oh   out  N    one-hot winner (all-zero when !valid)
//     gnt_idx  out  IW   index of the winner (0 when !valid)
// -----------------------------------------------------------------------------
module rr_arbiter
    import internal_bus_arbiter_pkg::*;
#(
    parameter  int N  = IBA_DEF_NCH,
    localparam int IW = iba_idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand_idx;

    // Walk the N positions after ptr; ptr itself is visited last so the
    // channel just served has the lowest priority.
    always_comb begin
        valid    = 1'b0;
        gnt_oh   = '0;
        gnt_idx  = '0;
        cand_idx = '0;
        for (int i = 1; i <= N; i++) begin
            cand_idx = IW'((int'(ptr) + i) % N);
            if (!valid && req[cand_idx]) begin
                valid            = 1'b1;
                gnt_idx          = cand_idx;
                gnt_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/internal_bus_arbiter.sv
// -----------------------------------------------------------------------------
// internal_bus_arbiter
//   Round-robin master for the core's internal bus. NCH requester channels
//   share one read_q/write_q handshake; one transaction is outstanding at a
//   time. Read data and per-channel done/err pulses go back to the owner.
//
//   Optional feature (macro INTERNAL_BUS_TIMEOUT_EN): a TMO_W-bit counter
//   aborts a transaction whose dn never arrives, pulsing done+err and
//   returning rdata=0. Without the macro ISSUE waits forever and err is 0.
//
//   Ports:
//     clk        in   1          core clock, all state on posedge
//     rst        in   1          asynchronous active-low reset
//     req_rd     in   NCH        per-channel read request (level)
//     req_wr     in   NCH        per-channel write request (level)
//     req_addr   in   NCH*ADDR_W channel i at [i*ADDR_W +: ADDR_W]
//     req_wdata  in   NCH*DATA_W channel i at [i*DATA_W +: DATA_W]
//     gnt        out  NCH        one-hot owner of the current transaction
//     done       out  NCH        one-cycle completion pulse to the owner
//     err        out  NCH        one-cycle timeout pulse, coincident with done
//     rdata      out  DATA_W     read data, held until the next completion
//     bus        master modport of internal_bus_arbiter_if
// -----------------------------------------------------------------------------
module internal_bus_arbiter
    import internal_bus_arbiter_pkg::*;
#(
    parameter int NCH    = IBA_DEF_NCH,
    parameter int ADDR_W = IBA_DEF_ADDR_W,
    parameter int DATA_W = IBA_DEF_DATA_W,
    parameter int TMO_W  = IBA_DEF_TMO_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req_rd,
    input  logic [NCH-1:0]        req_wr,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic [NCH*DATA_W-1:0] req_wdata,
    output logic [NCH-1:0]        gnt,
    output logic [NCH-1:0]        done,
    output logic [NCH-1:0]        err,
    output logic [DATA_W-1:0]     rdata,
    internal_bus_arbiter_if.master bus
);

    localparam int IW = iba_idx_w(NCH);

    if (NCH < 2 || NCH > 16) begin : g_bad_nch
        $error("internal_bus_arbiter: NCH must be in 2..16");
    end
    if (TMO_W < 2) begin : g_bad_tmo
        $error("internal_bus_arbiter: TMO_W must be at least 2");
    end

    iba_state_e        state;
    iba_op_e           op_q;
    logic [IW-1:0]     ptr_q;
    logic [IW-1:0]     owner_q;
    logic [NCH-1:0]    gnt_q;
    logic [NCH-1:0]    done_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_out_q;
    logic [DATA_W-1:0] data_out_q;
    logic              rd_strobe;
    logic              wr_strobe;

    logic [NCH-1:0]    cand;
    logic              pick_valid;
    logic [NCH-1:0]    pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              dn_hit;

`ifdef INTERNAL_BUS_TIMEOUT_EN
    // Abort happens in the ISSUE cycle where the counter would reach
    // all-ones, so the strobe is up for exactly 2**TMO_W - 1 cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0]  tmo_cnt;
    logic [NCH-1:0]    err_q;

    assign err = err_q;
`else
    assign err = '0;
`endif

    // A channel whose done is high has not had a chance to drop its request
    // yet, so it must not be granted again in the same cycle.
    assign cand = (req_rd | req_wr) & ~done_q;

    // Only the dn matching the latched operation completes the transaction.
    assign dn_hit = (op_q == OP_WR) ? bus.write_dn : bus.read_dn;

    rr_arbiter #(
        .N (NCH)
    ) u_rr (
        .req     (cand),
        .ptr     (ptr_q),
        .valid   (pick_valid),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx)
    );

    // Single FSM with registered outputs. DONE arbitrates exactly like IDLE
    // so another channel can be granted while done is pulsing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IBA_IDLE;
            op_q       <= OP_RD;
            ptr_q      <= IW'(NCH - 1);
            owner_q    <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
            addr_out_q <= '0;
            data_out_q <= '0;
            rd_strobe  <= 1'b0;
            wr_strobe  <= 1'b0;
`ifdef INTERNAL_BUS_TIMEOUT_EN
            tmo_cnt    <= '0;
            err_q      <= '0;
`endif
        end else begin
            done_q <= '0;
`ifdef INTERNAL_BUS_TIMEOUT_EN
            err_q  <= '0;
`endif
            case (state)
                IBA_IDLE, IBA_DONE: begin
                    state <= IBA_IDLE;
                    if (pick_valid && !bus.bus_busy) begin
                        state      <= IBA_ISSUE;
                        gnt_q      <= pick_oh;
                        owner_q    <= pick_idx;
                        addr_out_q <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        // Write wins when a channel raises both requests.
                        if (req_wr[pick_idx]) begin
                            op_q       <= OP_WR;
                            wr_strobe  <= 1'b1;
                            data_out_q <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        end else begin
                            op_q       <= OP_RD;
                            rd_strobe  <= 1'b1;
                            data_out_q <= '0;
                        end
`ifdef INTERNAL_BUS_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end

                IBA_ISSUE: begin
                    if (dn_hit) begin
                        rd_strobe  <= 1'b0;
                        wr_strobe  <= 1'b0;
                        addr_out_q <= '0;
                        data_out_q <= '0;
                        done_q     <= gnt_q;
                        if (op_q == OP_RD) begin
                            rdata_q <= bus.data_in;
                        end
                        ptr_q      <= owner_q;
                        gnt_q      <= '0;
                        state      <= IBA_DONE;
                    end
`ifdef INTERNAL_BUS_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        rd_strobe  <= 1'b0;
                        wr_strobe  <= 1'b0;
                        addr_out_q <= '0;
                        data_out_q <= '0;
                        done_q     <= gnt_q;
                        err_q      <= gnt_q;
                        rdata_q    <= '0;
                        ptr_q      <= owner_q;
                        gnt_q      <= '0;
                        state      <= IBA_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end

                default: state <= IBA_IDLE;
            endcase
        end
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign bus.addr_out = addr_out_q;
    assign bus.data_out = data_out_q;
    assign bus.read_q   = rd_strobe;
    assign bus.write_q  = wr_strobe;

endmodule

// File: tb/tb_internal_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_internal_bus_arbiter
//   Self-checking bench for internal_bus_arbiter. Expected transactions are
//   queued as requests are raised and popped when done pulses. Inputs change
//   and outputs are sampled on the falling clock edge. Build with
//   INTERNAL_BUS_TIMEOUT_EN defined to exercise the timeout scenarios.
// -----------------------------------------------------------------------------
module tb_internal_bus_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TW  = 4;

    typedef struct {
        int          ch;
        logic        wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NCH-1:0]      req_rd;
    logic [NCH-1:0]      req_wr;
    logic [NCH*AW-1:0]   req_addr;
    logic [NCH*DW-1:0]   req_wdata;
    logic [NCH-1:0]      gnt;
    logic [NCH-1:0]      done;
    logic [NCH-1:0]      err;
    logic [DW-1:0]       rdata;

    internal_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    internal_bus_arbiter #(
        .NCH    (NCH),
        .ADDR_W (AW),
        .DATA_W (DW),
        .TMO_W  (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus       (bif)
    );

    always #5 clk = ~clk;

    int            n_compared   = 0;
    int            n_mismatched = 0;
    exp_t          sb[$];
    int            model_ptr    = NCH - 1;
    logic [DW-1:0] last_rdata   = '0;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input int ch, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rd[ch]              = rd;
        req_wr[ch]              = wr;
        req_addr[ch*AW +: AW]   = a;
        req_wdata[ch*DW +: DW]  = d;
    endtask

    // Waits up to budget falling edges for a strobe; no comparison here.
    task automatic wait_strobe(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bif.read_q === 1'b1 || bif.write_q === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference round-robin choice: first candidate after model_ptr.
    function automatic int model_pick(input logic [NCH-1:0] c);
        for (int i = 1; i <= NCH; i++) begin
            if (c[(model_ptr + i) % NCH]) return (model_ptr + i) % NCH;
        end
        return -1;
    endfunction

    function automatic exp_t make_exp(input int ch, input logic wr, input logic [AW-1:0] a,
                                      input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                                      input logic e);
        exp_t x;
        x.ch = ch; x.wr = wr; x.addr = a; x.wdata = wd; x.rdata = rd; x.err = e;
        return x;
    endfunction

    function automatic logic [NCH-1:0] onehot(input int ch);
        logic [NCH-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        tick();
        n_compared++;
        if ({gnt, done, err, rdata, bif.addr_out, bif.data_out, bif.read_q, bif.write_q} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: got gnt=%b done=%b err=%b rdata=%h addr=%h data=%h rq=%b wq=%b, expected all zero",
                     gnt, done, err, rdata, bif.addr_out, bif.data_out, bif.read_q, bif.write_q);
        end
        rst = 1'b1;
        tick();
        tick();
        n_compared++;
        if ({gnt, done, bif.read_q, bif.write_q} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_after_reset: got gnt=%b done=%b rq=%b wq=%b, expected all zero",
                     gnt, done, bif.read_q, bif.write_q);
        end
        model_ptr = NCH - 1;
    endtask

    task automatic test_round_robin();
        logic [NCH-1:0] reqs;
        int             prev;
        int             ch;
        bit             ok;
        exp_t           e;
        reqs = 4'b1011;
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            ch = model_pick(reqs & ~((prev >= 0) ? onehot(prev) : '0));
            sb.push_back(make_exp(ch, 1'b0, 32'h1000 + 32'(ch) * 32'h10, '0, 32'hA000_0000 + 32'(k), 1'b0));
            model_ptr = ch;
            prev = ch;
        end
        for (int c = 0; c < NCH; c++) begin
            if (reqs[c]) set_req(c, 1'b1, 1'b0, 32'h1000 + 32'(c) * 32'h10, '0);
        end
        for (int k = 0; k < 6; k++) begin
            wait_strobe(1, ok);
            n_compared++;
            if (!ok) begin
                n_mismatched++;
                $display("[TB] FAIL rr_strobe[%0d]: got no strobe, expected read_q one cycle after request/done", k);
                break;
            end
            e = sb[0];
            n_compared++;
            if ({bif.read_q, bif.write_q, gnt, bif.addr_out} !== {1'b1, 1'b0, onehot(e.ch), e.addr}) begin
                n_mismatched++;
                $display("[TB] FAIL rr_grant[%0d]: got rq=%b wq=%b gnt=%b addr=%h, expected rq=1 wq=0 gnt=%b addr=%h",
                         k, bif.read_q, bif.write_q, gnt, bif.addr_out, onehot(e.ch), e.addr);
            end
            bif.read_dn = 1'b1;
            bif.data_in = e.rdata;
            tick();
            e = sb.pop_front();
            n_compared++;
            if ({done, err, rdata, bif.read_q, bif.addr_out} !== {onehot(e.ch), 4'b0000, e.rdata, 1'b0, 32'h0}) begin
                n_mismatched++;
                $display("[TB] FAIL rr_done[%0d]: got done=%b err=%b rdata=%h rq=%b addr=%h, expected done=%b err=0000 rdata=%h rq=0 addr=0",
                         k, done, err, rdata, bif.read_q, bif.addr_out, onehot(e.ch), e.rdata);
            end
            last_rdata  = e.rdata;
            bif.read_dn = 1'b0;
            bif.data_in = '0;
            if (k == 5) begin
                req_rd = '0;
            end
        end
        sb.delete();
    endtask

    task automatic test_single_read();
        bit   ok;
        exp_t e;
        set_req(2, 1'b1, 1'b0, 32'h100, '0);
        sb.push_back(make_exp(2, 1'b0, 32'h100, '0, 32'hDEAD_BEEF, 1'b0));
        wait_strobe(1, ok);
        n_compared++;
        if (!ok || {gnt, bif.addr_out, bif.data_out} !== {4'b0100, 32'h100, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL single_issue: got strobe=%b gnt=%b addr=%h data=%h, expected strobe=1 gnt=0100 addr=00000100 data=0",
                     ok, gnt, bif.addr_out, bif.data_out);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_compared++;
            if ({bif.read_q, done, bif.addr_out} !== {1'b1, 4'b0000, 32'h100}) begin
                n_mismatched++;
                $display("[TB] FAIL single_hold[%0d]: got rq=%b done=%b addr=%h, expected rq=1 done=0000 addr=00000100",
                         i, bif.read_q, done, bif.addr_out);
            end
        end
        bif.read_dn = 1'b1;
        bif.data_in = 32'hDEAD_BEEF;
        tick();
        e = sb.pop_front();
        n_compared++;
        if ({done, err, rdata, bif.read_q} !== {onehot(e.ch), 4'b0000, e.rdata, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL single_done: got done=%b err=%b rdata=%h rq=%b, expected done=%b err=0000 rdata=%h rq=0",
                     done, err, rdata, bif.read_q, onehot(e.ch), e.rdata);
        end
        last_rdata  = e.rdata;
        model_ptr   = 2;
        bif.read_dn = 1'b0;
        bif.data_in = '0;
        req_rd[2]   = 1'b0;
        tick();
        n_compared++;
        if ({done, gnt, bif.addr_out, bif.read_q, rdata} !== {4'b0000, 4'b0000, 32'h0, 1'b0, last_rdata}) begin
            n_mismatched++;
            $display("[TB] FAIL single_after: got done=%b gnt=%b addr=%h rq=%b rdata=%h, expected zeros with rdata=%h",
                     done, gnt, bif.addr_out, bif.read_q, rdata, last_rdata);
        end
    endtask

    task automatic test_bus_busy();
        bit   ok;
        bit   seen;
        exp_t e;
        bif.bus_busy = 1'b1;
        set_req(1, 1'b1, 1'b0, 32'h200, '0);
        sb.push_back(make_exp(model_pick(4'b0010), 1'b0, 32'h200, '0, 32'h1234_5678, 1'b0));
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bif.read_q === 1'b1 || bif.write_q === 1'b1 || gnt !== '0) seen = 1'b1;
        end
        n_compared++;
        if (seen !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL busy_block: got strobe/grant while bus_busy=1, expected none");
        end
        bif.bus_busy = 1'b0;
        wait_strobe(1, ok);
        e = sb[0];
        n_compared++;
        if (!ok || {gnt, bif.addr_out} !== {onehot(e.ch), e.addr}) begin
            n_mismatched++;
            $display("[TB] FAIL busy_release: got strobe=%b gnt=%b addr=%h, expected strobe=1 gnt=%b addr=%h",
                     ok, gnt, bif.addr_out, onehot(e.ch), e.addr);
        end
        bif.bus_busy = 1'b1;
        tick();
        n_compared++;
        if ({bif.read_q, done} !== {1'b1, 4'b0000}) begin
            n_mismatched++;
            $display("[TB] FAIL busy_mid_issue: got rq=%b done=%b, expected rq=1 done=0000", bif.read_q, done);
        end
        bif.read_dn = 1'b1;
        bif.data_in = 32'h1234_5678;
        tick();
        e = sb.pop_front();
        n_compared++;
        if ({done, err, rdata, bif.read_q} !== {onehot(e.ch), 4'b0000, e.rdata, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL busy_done: got done=%b err=%b rdata=%h rq=%b, expected done=%b err=0000 rdata=%h rq=0",
                     done, err, rdata, bif.read_q, onehot(e.ch), e.rdata);
        end
        last_rdata   = e.rdata;
        model_ptr    = e.ch;
        bif.read_dn  = 1'b0;
        bif.data_in  = '0;
        bif.bus_busy = 1'b0;
        req_rd[1]    = 1'b0;
        tick();
    endtask

    task automatic test_rd_wr_priority();
        bit   ok;
        exp_t e;
        set_req(3, 1'b1, 1'b1, 32'h300, 32'hCAFE_F00D);
        sb.push_back(make_exp(3, 1'b1, 32'h300, 32'hCAFE_F00D, last_rdata, 1'b0));
        wait_strobe(1, ok);
        e = sb[0];
        n_compared++;
        if (!ok || {bif.read_q, bif.write_q, gnt, bif.addr_out, bif.data_out} !==
                   {1'b0, 1'b1, onehot(e.ch), e.addr, e.wdata}) begin
            n_mismatched++;
            $display("[TB] FAIL wr_issue: got rq=%b wq=%b gnt=%b addr=%h data=%h, expected rq=0 wq=1 gnt=%b addr=%h data=%h",
                     bif.read_q, bif.write_q, gnt, bif.addr_out, bif.data_out, onehot(e.ch), e.addr, e.wdata);
        end
        bif.read_dn = 1'b1;
        bif.data_in = 32'h5555_5555;
        tick();
        n_compared++;
        if ({bif.write_q, done} !== {1'b1, 4'b0000}) begin
            n_mismatched++;
            $display("[TB] FAIL wr_ignores_read_dn: got wq=%b done=%b, expected wq=1 done=0000", bif.write_q, done);
        end
        bif.read_dn  = 1'b0;
        bif.write_dn = 1'b1;
        tick();
        e = sb.pop_front();
        n_compared++;
        if ({done, err, rdata, bif.write_q, bif.data_out, bif.addr_out} !==
            {onehot(e.ch), 4'b0000, e.rdata, 1'b0, 32'h0, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL wr_done: got done=%b err=%b rdata=%h wq=%b data=%h addr=%h, expected done=%b err=0000 rdata=%h wq=0 data=0 addr=0",
                     done, err, rdata, bif.write_q, bif.data_out, bif.addr_out, onehot(e.ch), e.rdata);
        end
        model_ptr    = 3;
        bif.write_dn = 1'b0;
        bif.data_in  = '0;
        req_rd[3]    = 1'b0;
        req_wr[3]    = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_issue();
        bit   ok;
        bit   seen_done;
        exp_t e;
        set_req(0, 1'b1, 1'b0, 32'h400, '0);
        sb.push_back(make_exp(model_pick(4'b0001), 1'b0, 32'h400, '0, 32'h0, 1'b0));
        wait_strobe(1, ok);
        n_compared++;
        if (!ok || gnt !== 4'b0001) begin
            n_mismatched++;
            $display("[TB] FAIL rst_pre_issue: got strobe=%b gnt=%b, expected strobe=1 gnt=0001", ok, gnt);
        end
        tick();
        #2 rst = 1'b0;
        #1;
        n_compared++;
        if ({gnt, done, err, rdata, bif.addr_out, bif.data_out, bif.read_q, bif.write_q} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_async_clear: got gnt=%b done=%b rdata=%h addr=%h rq=%b wq=%b, expected all zero",
                     gnt, done, rdata, bif.addr_out, bif.read_q, bif.write_q);
        end
        sb.delete();
        last_rdata  = '0;
        model_ptr   = NCH - 1;
        bif.read_dn = 1'b1;
        bif.data_in = 32'h9999_9999;
        seen_done   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (done !== '0 || bif.read_q !== 1'b0) seen_done = 1'b1;
        end
        n_compared++;
        if (seen_done !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rst_no_done: got done/strobe activity during reset, expected none");
        end
        bif.read_dn = 1'b0;
        bif.data_in = '0;
        rst = 1'b1;
        sb.push_back(make_exp(model_pick(4'b0001), 1'b0, 32'h400, '0, 32'h0BAD_F00D, 1'b0));
        wait_strobe(1, ok);
        e = sb[0];
        n_compared++;
        if (!ok || {gnt, bif.addr_out} !== {onehot(e.ch), e.addr}) begin
            n_mismatched++;
            $display("[TB] FAIL rst_rearbitrate: got strobe=%b gnt=%b addr=%h, expected strobe=1 gnt=%b addr=%h",
                     ok, gnt, bif.addr_out, onehot(e.ch), e.addr);
        end
        bif.read_dn = 1'b1;
        bif.data_in = 32'h0BAD_F00D;
        tick();
        e = sb.pop_front();
        n_compared++;
        if ({done, rdata} !== {onehot(e.ch), e.rdata}) begin
            n_mismatched++;
            $display("[TB] FAIL rst_after_done: got done=%b rdata=%h, expected done=%b rdata=%h",
                     done, rdata, onehot(e.ch), e.rdata);
        end
        last_rdata  = e.rdata;
        model_ptr   = e.ch;
        bif.read_dn = 1'b0;
        bif.data_in = '0;
        req_rd[0]   = 1'b0;
        tick();
    endtask

`ifdef INTERNAL_BUS_TIMEOUT_EN
    task automatic test_timeout();
        bit   ok;
        int   cycles;
        exp_t e;
        set_req(1, 1'b1, 1'b0, 32'h500, '0);
        sb.push_back(make_exp(1, 1'b0, 32'h500, '0, 32'h0, 1'b1));
        wait_strobe(1, ok);
        cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (bif.read_q !== 1'b1) break;
            cycles++;
            tick();
        end
        n_compared++;
        if (!ok || cycles != (2 ** TW) - 1) begin
            n_mismatched++;
            $display("[TB] FAIL tmo_length: got %0d strobe cycles, expected %0d", cycles, (2 ** TW) - 1);
        end
        e = sb.pop_front();
        n_compared++;
        if ({done, err, rdata, bif.addr_out} !== {onehot(e.ch), onehot(e.ch), e.rdata, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL tmo_abort: got done=%b err=%b rdata=%h addr=%h, expected done=%b err=%b rdata=0 addr=0",
                     done, err, rdata, bif.addr_out, onehot(e.ch), onehot(e.ch));
        end
        req_rd[1] = 1'b0;
        tick();
        set_req(1, 1'b1, 1'b0, 32'h500, '0);
        sb.push_back(make_exp(1, 1'b0, 32'h500, '0, 32'h0000_0077, 1'b0));
        wait_strobe(1, ok);
        for (int i = 1; i < (2 ** TW) - 1; i++) tick();
        n_compared++;
        if (!ok || bif.read_q !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL tmo_last_cycle: got rq=%b, expected rq=1 in final ISSUE cycle", bif.read_q);
        end
        bif.read_dn = 1'b1;
        bif.data_in = 32'h0000_0077;
        tick();
        e = sb.pop_front();
        n_compared++;
        if ({done, err, rdata} !== {onehot(e.ch), 4'b0000, e.rdata}) begin
            n_mismatched++;
            $display("[TB] FAIL tmo_dn_wins: got done=%b err=%b rdata=%h, expected done=%b err=0000 rdata=%h",
                     done, err, rdata, onehot(e.ch), e.rdata);
        end
        bif.read_dn = 1'b0;
        bif.data_in = '0;
        req_rd[1]   = 1'b0;
        tick();
    endtask
`endif

    initial begin
        req_rd       = '0;
        req_wr       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        bif.bus_busy = 1'b0;
        bif.data_in  = '0;
        bif.read_dn  = 1'b0;
        bif.write_dn = 1'b0;

        test_reset();
        test_round_robin();
        test_single_read();
        test_bus_busy();
        test_rd_wr_priority();
        test_reset_mid_issue();
`ifdef INTERNAL_BUS_TIMEOUT_EN
        test_timeout();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
